// File: rtl/fix_to_fp_pkg.sv
// Shared floating-point format used by the fixed-to-float converter and the fp datapath.
package fix_to_fp_pkg;

    localparam int FP_EXP_BITS  = 8;
    localparam int FP_MANT_BITS = 7;
    localparam int FP_EXP_BIAS  = 127;
    localparam int FP_WIDTH     = 1 + FP_EXP_BITS + FP_MANT_BITS;
    localparam int FP_EXP_MAX   = (1 << FP_EXP_BITS) - 1;

    typedef struct packed {
        logic                    sign;
        logic [FP_EXP_BITS-1:0]  exp;
        logic [FP_MANT_BITS-1:0] mant;
    } fp;

    localparam fp fp_zero = '0;

endpackage

// File: rtl/fix_to_fp_clz.sv
// Parameterised count-leading-zeros; an all-zero input returns WIDTH.
module clz #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = CW'(WIDTH);
        // Ascending scan: the highest set bit is the last to write.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fix_to_fp.sv
// Signed fixed-point to fp converter, 2-stage valid/ready pipeline.
// Define FIX_TO_FP_ROUND_EN for round-to-nearest-even instead of truncation.
module fix_to_fp
    import fix_to_fp_pkg::*;
#(
    parameter int FIX_WIDTH = 32,
    parameter int FIX_FRAC  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FIX_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FP_WIDTH-1:0]  out_fp
);

    localparam int EW      = FP_EXP_BITS + 2;
    localparam int LZW     = $clog2(FIX_WIDTH + 1);
    localparam int EXP_OFS = FP_EXP_BIAS + FIX_WIDTH - 1 - FIX_FRAC;

    logic                 s1_valid;
    logic                 s1_sign;
    logic                 s1_zero;
    logic [FIX_WIDTH-1:0] s1_mag;
    logic                 s1_adv;
    logic                 s2_adv;

    logic [LZW-1:0]          lz;
    logic [FIX_WIDTH-2:0]    norm_low;
    logic [FP_MANT_BITS-1:0] mant;
    logic signed [EW-1:0]    exp_s;
    fp                       res;
`ifdef FIX_TO_FP_ROUND_EN
    logic [FIX_WIDTH-2:0]    lower;
    logic                    guard;
    logic                    sticky;
    logic                    carry;
`endif

    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_fp    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_fp <= res;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_sign <= in_data[FIX_WIDTH-1];
            s1_zero <= (in_data == '0);
            // Unsigned negate: the most negative input yields 2^(FIX_WIDTH-1) exactly.
            s1_mag  <= in_data[FIX_WIDTH-1] ? -in_data : in_data;
        end
    end

    clz #(.WIDTH(FIX_WIDTH)) u_clz (
        .value (s1_mag),
        .count (lz)
    );

    always_comb begin
        // Hidden 1 is dropped; the fraction is left-aligned and zero-padded below.
        norm_low = (FIX_WIDTH-1)'(s1_mag << lz);
        mant     = FP_MANT_BITS'({norm_low, {FP_MANT_BITS{1'b0}}} >> (FIX_WIDTH - 1));
        exp_s    = $signed(EW'(EXP_OFS)) - $signed(EW'(lz));
`ifdef FIX_TO_FP_ROUND_EN
        lower  = (FIX_WIDTH-1)'({norm_low, {FP_MANT_BITS{1'b0}}});
        guard  = lower[FIX_WIDTH-2];
        sticky = |(lower << 1);
        {carry, mant} = {1'b0, mant} + {{FP_MANT_BITS{1'b0}}, guard & (sticky | mant[0])};
        if (carry) begin
            exp_s = exp_s + $signed(EW'(1));
        end
`endif
        res = fp_zero;
        if (s1_zero || exp_s <= $signed(EW'(0))) begin
            res = fp_zero;
        end else if (exp_s >= $signed(EW'(FP_EXP_MAX))) begin
            res.sign = s1_sign;
            res.exp  = FP_EXP_BITS'(FP_EXP_MAX - 1);
            res.mant = '1;
        end else begin
            res.sign = s1_sign;
            res.exp  = exp_s[FP_EXP_BITS-1:0];
            res.mant = mant;
        end
    end

endmodule

// File: tb/tb_fix_to_fp.sv
// Bench for fix_to_fp: directed values, backpressure, random traffic, mid-stream reset.
// Expectations follow FIX_TO_FP_ROUND_EN when it is defined.
module tb_fix_to_fp;
    import fix_to_fp_pkg::*;

    localparam int FIX_WIDTH = 32;
    localparam int FIX_FRAC  = 16;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 in_ready;
    logic [FIX_WIDTH-1:0] in_data   = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [FP_WIDTH-1:0]  out_fp;

    always #5 clk = ~clk;

    fix_to_fp #(.FIX_WIDTH(FIX_WIDTH), .FIX_FRAC(FIX_FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_out    = 0;

    logic [FP_WIDTH-1:0] exp_q[$];
    logic                hold_pending = 1'b0;
    logic [FP_WIDTH-1:0] held = '0;
    logic                last_acc, last_out_xfer, last_in_ready;
    logic [FP_WIDTH-1:0] last_out = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: value = in_data / 2^FIX_FRAC, normalised by locating the top set bit.
    function automatic logic [FP_WIDTH-1:0] model(input logic [FIX_WIDTH-1:0] d);
        longint v, mag, mfull, rem, half;
        int     p, e, sh;
        logic   s;
        fp      r;
        v   = longint'($signed(d));
        s   = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) return '0;
        p = 0;
        for (int k = 0; k < 64; k++) if (((mag >> k) & 1) != 0) p = k;
        e = FP_EXP_BIAS + p - FIX_FRAC;
        if (p >= FP_MANT_BITS) begin
            sh    = p - FP_MANT_BITS;
            mfull = mag >> sh;
`ifdef FIX_TO_FP_ROUND_EN
            if (sh > 0) begin
                rem  = mag & ((64'sd1 << sh) - 1);
                half = 64'sd1 << (sh - 1);
                if (rem > half || (rem == half && mfull[0])) mfull++;
            end
            if (mfull == (64'sd1 << (FP_MANT_BITS + 1))) begin
                mfull = mfull >> 1;
                e++;
            end
`endif
        end else begin
            mfull = mag << (FP_MANT_BITS - p);
        end
        rem  = 0;
        half = 0;
        if (e <= 0) return '0;
        r.sign = s;
        if (e >= FP_EXP_MAX) begin
            r.exp  = FP_EXP_BITS'(FP_EXP_MAX - 1);
            r.mant = '1;
        end else begin
            r.exp  = FP_EXP_BITS'(e);
            r.mant = FP_MANT_BITS'(mfull);
        end
        return r;
    endfunction

    // One clock: sample handshakes on the falling edge, score, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        last_in_ready = in_ready;
        last_acc      = in_valid && in_ready;
        last_out_xfer = out_valid && out_ready;
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_fp", 32'(out_fp), 32'(held));
        end
        hold_pending = out_valid && !out_ready;
        held         = out_fp;
        if (last_out_xfer) begin
            n_out++;
            last_out = out_fp;
            check("out_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("out_fp", 32'(out_fp), 32'(exp_q.pop_front()));
        end
        if (last_acc) begin
            n_acc++;
            exp_q.push_back(model(in_data));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] d, input logic [15:0] expv);
        int lat;
        bit done;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        tick();
        check({tag, "_acc"}, 32'(last_acc), 1);
        in_valid = 1'b0;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 8) begin
            tick();
            lat++;
            done = last_out_xfer;
        end
        check({tag, "_lat"}, lat, 2);
        check(tag, 32'(last_out), 32'(expv));
    endtask

    logic [31:0] bp_vals[5];
    int          idx, n_out0, sel;

    initial begin
        bp_vals = '{32'h0001_0000, 32'hFFFD_0000, 32'h0000_0001, 32'h8000_0000, 32'h0012_3456};

        rst = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_fp", 32'(out_fp), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b1;

        directed("one",      32'h0001_0000, 16'h3F80);
        directed("neg3",     32'hFFFD_0000, 16'hC040);
        directed("zero",     32'h0000_0000, 16'h0000);
        directed("most_neg", 32'h8000_0000, 16'hC700);
        directed("lsb",      32'h0000_0001, 16'h3780);
        directed("neg_lsb",  32'hFFFF_FFFF, 16'hB780);
`ifdef FIX_TO_FP_ROUND_EN
        directed("near_two", 32'h0001_FFFF, 16'h4000);
        directed("max_pos",  32'h7FFF_FFFF, 16'h4700);
`else
        directed("near_two", 32'h0001_FFFF, 16'h3FFF);
        directed("max_pos",  32'h7FFF_FFFF, 16'h46FF);
`endif

        // Five back-to-back values, downstream stalled for four cycles after the second accept.
        idx    = 0;
        n_out0 = n_out;
        for (int c = 0; c < 40 && (n_out - n_out0) < 5; c++) begin
            in_valid  = (idx < 5);
            in_data   = bp_vals[(idx < 5) ? idx : 4];
            out_ready = !(c >= 2 && c < 6);
            tick();
            if (last_acc) idx++;
            if (c == 1) check("bp_two_accepted", idx, 2);
            if (c == 2 || c == 5) check("bp_in_ready_low", 32'(last_in_ready), 0);
        end
        in_valid = 1'b0;
        check("bp_accepted", idx, 5);
        check("bp_emitted", n_out - n_out0, 5);
        check("bp_queue_empty", exp_q.size(), 0);

        for (int c = 0; c < 400; c++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       in_data = 32'h0000_0000;
                1:       in_data = 32'h8000_0000;
                2:       in_data = 32'h7FFF_FFFF;
                3:       in_data = 32'($urandom_range(0, 255));
                4:       in_data = -32'($urandom_range(1, 255));
                default: in_data = $urandom;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        check("rand_drained", exp_q.size(), 0);
        check("rand_count", n_out, n_acc);

        // Fill both stages, then reset: everything in flight must vanish.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0003_0000;
        tick();
        tick();
        tick();
        check("pre_rst_full", 32'(last_in_ready), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        hold_pending = 1'b0;
        check("post_rst_out_valid", 32'(out_valid), 0);
        check("post_rst_out_fp", 32'(out_fp), 0);
        check("post_rst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        n_out0    = n_out;
        repeat (6) tick();
        check("post_rst_no_stale", n_out - n_out0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
